// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the core's data-memory path: access-size encodings,
// data-memory controller states and the size/alignment helper.
package riscv_mem_pkg;

  localparam logic [1:0] WHB_BYTE = 2'b00;
  localparam logic [1:0] WHB_HALF = 2'b01;
  localparam logic [1:0] WHB_WORD = 2'b10;
  localparam logic [1:0] WHB_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // True when the access size does not fit the low address bits.
  function automatic logic size_misaligned(input logic [1:0] whb, input logic [1:0] lane);
    return ((whb == WHB_HALF) && lane[0]) || ((whb == WHB_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide data RAM with per-byte write enables; synchronous write and
// combinational read at the same word index. Contents are never reset.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller behind the core's MEM stage: captures one request,
// inserts WAIT_CYCLES wait states, then performs the RAM access and strobes d_ready.
module dmem_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_d_n,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  whb,
  output logic [31:0] d_data,
  output logic        d_ready,
  output logic        d_busy,
  output logic        d_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  // Handshake: a request (cs_d_n=0 with rd|wr) is accepted on the rising edge
  // while IDLE; the bus is then ignored until d_ready, a one-cycle strobe
  // qualifying d_err/d_data. d_busy covers acceptance through the d_ready cycle.

  dmem_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          accept, done;

  logic [AW-1:0] req_idx;
  logic [1:0]    req_lane;
  logic [31:0]   req_wdata;
  logic [1:0]    req_whb;
  logic          req_rd, req_wr, req_err;

  logic          acc_err;
  logic [3:0]    lane_be, ram_be;
  logic [31:0]   lane_wdata, ram_rdata;

  // Every error is resolved from the live bus at acceptance.
  assign acc_err = size_misaligned(whb, d_addr[1:0])
                 | (d_addr[31:2] >= 30'(DEPTH))
                 | (rd & wr)
                 | (whb == WHB_RSVD);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_d_n && (rd || wr)) begin
          accept     = 1'b1;
          cnt_next   = CW'(WAIT_CYCLES);
          state_next = (WAIT_CYCLES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CW'(1);
        if (cnt <= CW'(1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      d_ready   <= 1'b0;
      d_err     <= 1'b0;
      d_data    <= '0;
      req_idx   <= '0;
      req_lane  <= '0;
      req_wdata <= '0;
      req_whb   <= '0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      d_ready <= done;
      d_err   <= done & req_err;
      if (done && req_rd && !req_err) d_data <= ram_rdata;
      if (accept) begin
        req_idx   <= d_addr[AW+1:2];
        req_lane  <= d_addr[1:0];
        req_wdata <= d_wdata;
        req_whb   <= whb;
        req_rd    <= rd;
        req_wr    <= wr;
        req_err   <= acc_err;
      end
    end
  end

  // Replicate store data into every lane; the byte enables pick the real ones.
  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = req_wdata;
    case (req_whb)
      WHB_BYTE: begin
        lane_be    = 4'b0001 << req_lane;
        lane_wdata = {4{req_wdata[7:0]}};
      end
      WHB_HALF: begin
        lane_be    = req_lane[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      WHB_WORD: lane_be = 4'b1111;
      default:  lane_be = 4'b0000;
    endcase
  end

  assign ram_be = (done && req_wr && !req_err) ? lane_be : 4'b0000;
  assign d_busy = (state != IDLE) | d_ready;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .idx   (req_idx),
    .be    (ram_be),
    .wdata (lane_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, multi-cycle corner
// sequences, and randomized accesses scored against a word-array memory model.
module tb_dmem_ctrl;

  localparam int DEPTH = 1024;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_d_n, cs0_d_n, rd, wr;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  whb;
  logic [31:0] d_data, d0_data;
  logic        d_ready, d_busy, d_err;
  logic        d0_ready, d0_busy, d0_err;

  int checks = 0;
  int failures = 0;
  int spurious_err = 0;
  int busy_gap = 0;

  // Scoreboard: {err, d_data} expected for each completed access.
  logic [32:0] exp_q[$];
  logic [31:0] model_mem [int];
  logic [31:0] model_d = 32'h0;

  dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .cs_d_n(cs_d_n), .rd(rd), .wr(wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .whb(whb),
    .d_data(d_data), .d_ready(d_ready), .d_busy(d_busy), .d_err(d_err)
  );

  dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .cs_d_n(cs0_d_n), .rd(rd), .wr(wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .whb(whb),
    .d_data(d0_data), .d_ready(d0_ready), .d_busy(d0_busy), .d_err(d0_err)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    cs_d_n  = 1'b1;
    cs0_d_n = 1'b1;
    rd      = 1'b0;
    wr      = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    whb     = SZ_B;
  endtask

  // Driver: one request to the selected DUT, then wait (bounded) for d_ready.
  task automatic dut_access(input bit sel0, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s,
                            output int lat, output logic e, output logic [31:0] dat);
    @(negedge clk);
    rd = r; wr = w; d_addr = a; d_wdata = wd; whb = s;
    if (sel0) cs0_d_n = 1'b0; else cs_d_n = 1'b0;
    @(posedge clk); #1;
    drive_idle();
    lat = -1; e = 1'b0; dat = 32'h0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (!(sel0 ? d0_busy : d_busy)) busy_gap++;
      if (sel0 ? d0_ready : d_ready) begin
        lat = n;
        e   = sel0 ? d0_err : d_err;
        dat = sel0 ? d0_data : d_data;
        break;
      end
      if (sel0 ? d0_err : d_err) spurious_err++;
    end
  endtask

  // Reference model: a word array updated by byte masks derived from size and address.
  task automatic model_exec(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] s,
                            output logic e, output logic [31:0] dat);
    int unsigned idx, sh;
    logic [31:0] mask, cur;
    idx = a / 4;
    sh  = 8 * (a % 4);
    e = (r && w) || (s == SZ_R) || (s == SZ_H && (a % 2) != 0) ||
        (s == SZ_W && (a % 4) != 0) || (idx >= DEPTH);
    if (!e && w) begin
      cur  = model_mem.exists(int'(idx)) ? model_mem[int'(idx)] : 32'hx;
      mask = (s == SZ_B) ? (32'hFF << sh) : (s == SZ_H) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
      model_mem[int'(idx)] = (cur & ~mask) | ((wd << sh) & mask);
    end
    if (!e && r) model_d = model_mem.exists(int'(idx)) ? model_mem[int'(idx)] : 32'hx;
    dat = model_d;
  endtask

  task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] s,
                            output logic e, output logic [31:0] dat);
    logic me;
    logic [31:0] md;
    logic [32:0] exp;
    int lat;
    model_exec(r, w, a, wd, s, me, md);
    exp_q.push_back({me, md});
    dut_access(1'b0, r, w, a, wd, s, lat, e, dat);
    exp = exp_q.pop_front();
    check("latency", 32'(lat), 32'd3);
    check("model_err", {31'b0, e}, {31'b0, exp[32]});
    check("model_data", dat, exp[31:0]);
  endtask

  typedef struct {
    logic        r, w;
    logic [31:0] a, wd;
    logic [1:0]  s;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic        e;
    logic [31:0] dat;
    int          lat;
    int          p[$];

    drive_idle();
    rst = 1'b1;
    #1;
    check("rst_data", d_data, 32'h0);
    check("rst_ready", {31'b0, d_ready}, 32'h0);
    check("rst_busy", {31'b0, d_busy}, 32'h0);
    check("rst_err", {31'b0, d_err}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Directed vectors: word, byte/half lanes, misalignment, range and illegal requests.
    vecs = '{
      '{0, 1, 32'h10,   32'hDEADBEEF, SZ_W, 0, 32'h00000000},
      '{1, 0, 32'h10,   32'h0,        SZ_W, 0, 32'hDEADBEEF},
      '{0, 1, 32'h20,   32'h11223344, SZ_W, 0, 32'hDEADBEEF},
      '{0, 1, 32'h22,   32'h000000AA, SZ_B, 0, 32'hDEADBEEF},
      '{0, 1, 32'h20,   32'h0000BBCC, SZ_H, 0, 32'hDEADBEEF},
      '{1, 0, 32'h20,   32'h0,        SZ_W, 0, 32'h11AABBCC},
      '{0, 1, 32'h21,   32'h00001234, SZ_H, 1, 32'h11AABBCC},
      '{1, 0, 32'h20,   32'h0,        SZ_W, 0, 32'h11AABBCC},
      '{1, 0, 32'h22,   32'h0,        SZ_W, 1, 32'h11AABBCC},
      '{1, 0, 32'h1000, 32'h0,        SZ_W, 1, 32'h11AABBCC},
      '{1, 1, 32'h20,   32'h0,        SZ_W, 1, 32'h11AABBCC},
      '{1, 0, 32'h20,   32'h0,        SZ_W, 0, 32'h11AABBCC},
      '{0, 1, 32'h20,   32'hFFFFFFFF, SZ_R, 1, 32'h11AABBCC},
      '{1, 0, 32'h23,   32'h0,        SZ_B, 0, 32'h11AABBCC},
      '{0, 1, 32'h22,   32'h00005566, SZ_H, 0, 32'h11AABBCC},
      '{1, 0, 32'h22,   32'h0,        SZ_H, 0, 32'h5566BBCC}
    };
    for (int i = 0; i < 16; i++) begin
      run_access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].s, e, dat);
      check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_data", i), dat, vecs[i].exp_data);
    end

    // Zero wait states: d_ready one cycle after acceptance.
    dut_access(1'b1, 1'b0, 1'b1, 32'h40, 32'h13579BDF, SZ_W, lat, e, dat);
    check("w0_wr_latency", 32'(lat), 32'd1);
    check("w0_wr_err", {31'b0, e}, 32'h0);
    dut_access(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, SZ_W, lat, e, dat);
    check("w0_rd_latency", 32'(lat), 32'd1);
    check("w0_rd_data", dat, 32'h13579BDF);

    // Inputs changing during WAIT must not alter the captured request.
    run_access(1'b0, 1'b1, 32'h60, 32'h01020304, SZ_W, e, dat);
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; d_addr = 32'h50; d_wdata = 32'hA5A5A5A5; whb = SZ_W; cs_d_n = 1'b0;
    @(posedge clk); #1;
    d_addr = 32'h60; d_wdata = 32'hFFFFFFFF; whb = SZ_B;
    lat = -1; e = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (d_ready) begin lat = n; e = d_err; break; end
    end
    drive_idle();
    model_exec(1'b0, 1'b1, 32'h50, 32'hA5A5A5A5, SZ_W, e, dat);
    check("hold_latency", 32'(lat), 32'd3);
    run_access(1'b1, 1'b0, 32'h50, 32'h0, SZ_W, e, dat);
    check("hold_captured", dat, 32'hA5A5A5A5);
    run_access(1'b1, 1'b0, 32'h60, 32'h0, SZ_W, e, dat);
    check("hold_untouched", dat, 32'h01020304);

    // cs_d_n held low: one access every WAIT_CYCLES+2 cycles.
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; d_addr = 32'h10; whb = SZ_W; cs_d_n = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      if (d_ready) begin
        p.push_back(k);
        check("stream_data", d_data, 32'hDEADBEEF);
      end
    end
    drive_idle();
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (!d_busy) begin lat = n; break; end
    end
    check("stream_drain", {31'b0, lat > 0}, 32'h1);
    check("stream_count", 32'(p.size()), 32'd3);
    check("stream_first", 32'((p.size() > 0) ? p[0] : -1), 32'd3);
    check("stream_gap1", 32'((p.size() > 1) ? p[1] - p[0] : -1), 32'd4);
    check("stream_gap2", 32'((p.size() > 2) ? p[2] - p[1] : -1), 32'd4);
    model_exec(1'b1, 1'b0, 32'h10, 32'h0, SZ_W, e, dat);

    // Reset during WAIT abandons a write and clears outputs asynchronously.
    run_access(1'b0, 1'b1, 32'h30, 32'h0BADF00D, SZ_W, e, dat);
    run_access(1'b1, 1'b0, 32'h30, 32'h0, SZ_W, e, dat);
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFE0000; whb = SZ_W; cs_d_n = 1'b0;
    @(posedge clk); #1;
    drive_idle();
    check("abort_busy", {31'b0, d_busy}, 32'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_data", d_data, 32'h0);
    check("abort_ready", {31'b0, d_ready}, 32'h0);
    check("abort_busy_clr", {31'b0, d_busy}, 32'h0);
    check("abort_err", {31'b0, d_err}, 32'h0);
    model_d = 32'h0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    run_access(1'b1, 1'b0, 32'h30, 32'h0, SZ_W, e, dat);
    check("abort_ram_kept", dat, 32'h0BADF00D);

    // Randomized accesses over a small pre-initialized window.
    for (int i = 0; i < 32; i++) run_access(1'b0, 1'b1, 32'(i * 4), $urandom, SZ_W, e, dat);
    for (int i = 0; i < 150; i++) begin
      int unsigned kind;
      logic r, w;
      logic [31:0] a;
      logic [1:0]  s;
      kind = $urandom_range(0, 19);
      r = 1'($urandom_range(0, 1));
      w = ~r;
      a = 32'($urandom_range(0, 127));
      s = ($urandom_range(0, 9) == 0) ? SZ_R : 2'($urandom_range(0, 2));
      if (kind == 0) begin r = 1'b1; w = 1'b1; end
      if (kind == 1) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4000));
      if (kind == 2) a = 32'hFFFF_FFF0;
      run_access(r, w, a, $urandom, s, e, dat);
    end

    check("err_without_ready", 32'(spurious_err), 32'd0);
    check("busy_while_pending", 32'(busy_gap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
